// File: rtl/conv_sa_pe_row_mw.sv
// Row of P output-stationary PEs for the conv systolic array, NW weight lanes per PE.
// Weights and vector flags ripple one PE per cycle through the stage-A skew registers.
// Activations are latched per column and forwarded to the row below. Each PE
// multiplies, accumulates (wrap or saturate) and drains finished sums into a
// registered psum chain shared with the rows above.

// Single PE: stage B (multiply) and stage C (accumulate / drain).
// Stage A lives in the row so the skew chain is one contiguous register string.
module conv_sa_pe_mw #(
    parameter int NW  = 2,
    parameter int PW  = 19,
    parameter int SAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NW*8-1:0]  w_a,
    input  logic             vld_a,
    input  logic             rst_a,
    input  logic             flush_a,
    input  logic [7:0]       x_a,
    input  logic [NW*PW-1:0] psum_in,
    input  logic             psum_vld_in,
    output logic [NW*PW-1:0] psum_out,
    output logic             psum_vld_out,
    output logic             ovf,
    output logic             coll
);

    localparam logic [PW-1:0] ACC_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic [PW-1:0] ACC_MIN = {1'b1, {(PW-1){1'b0}}};

    logic [NW-1:0][15:0]   prod_nxt;
    logic [NW-1:0][15:0]   prod_b;
    logic                  vld_b;
    logic                  rst_b;
    logic                  flush_b;
    logic [NW-1:0][PW-1:0] acc;
    logic [NW-1:0][PW-1:0] acc_nxt;
    logic [NW-1:0][PW:0]   base_c;
    logic [NW-1:0][PW:0]   sum_c;
    logic [NW-1:0]         lane_ovf;
    logic                  do_flush;

    // Signed int8 x int8 per lane; full 16-bit product never overflows.
    always_comb begin
        prod_nxt = '0;
        for (int k = 0; k < NW; k++) begin
            prod_nxt[k] = $signed({{8{w_a[k*8+7]}}, w_a[k*8 +: 8]}) *
                          $signed({{8{x_a[7]}}, x_a});
        end
    end

    // Stage B: register products; flags travel alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_b  <= '0;
            vld_b   <= 1'b0;
            rst_b   <= 1'b0;
            flush_b <= 1'b0;
        end else begin
            prod_b  <= prod_nxt;
            vld_b   <= vld_a;
            rst_b   <= rst_a;
            flush_b <= flush_a;
        end
    end

    // Stage C add at PW+1 bits; a mismatch of the top two bits means the
    // true sum left the signed PW range. Wrap keeps the low bits, SAT clamps.
    always_comb begin
        base_c   = '0;
        sum_c    = '0;
        lane_ovf = '0;
        acc_nxt  = acc;
        for (int k = 0; k < NW; k++) begin
            base_c[k]   = rst_b ? '0 : {acc[k][PW-1], acc[k]};
            sum_c[k]    = base_c[k] + {{(PW+1-16){prod_b[k][15]}}, prod_b[k]};
            lane_ovf[k] = sum_c[k][PW] ^ sum_c[k][PW-1];
            if (lane_ovf[k] && (SAT != 0))
                acc_nxt[k] = sum_c[k][PW] ? ACC_MIN : ACC_MAX;
            else
                acc_nxt[k] = sum_c[k][PW-1:0];
        end
    end

    assign do_flush = vld_b & flush_b;

    // Accumulators and sticky overflow only move on valid elements;
    // a restarting element clears the old overflow before adding its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (vld_b) begin
            acc <= acc_nxt;
            ovf <= (ovf & ~rst_b) | (|lane_ovf);
        end
    end

    // Drain chain: a local flush overrides the upstream word (flagged as a
    // collision); otherwise the upstream word passes with one cycle of delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psum_out     <= '0;
            psum_vld_out <= 1'b0;
            coll         <= 1'b0;
        end else if (do_flush) begin
            psum_out     <= acc_nxt;
            psum_vld_out <= 1'b1;
            coll         <= coll | psum_vld_in;
        end else begin
            psum_out     <= psum_in;
            psum_vld_out <= psum_vld_in;
        end
    end

endmodule

module conv_sa_pe_row_mw #(
    parameter int P   = 8,
    parameter int NW  = 2,
    parameter int PW  = 19,
    parameter int SAT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NW*8-1:0]      in_w,
    input  logic                 in_vld,
    input  logic                 in_rst,
    input  logic                 in_flush,
    input  logic [P*8-1:0]       in_x,
    input  logic [P*NW*PW-1:0]   in_psum,
    input  logic [P-1:0]         in_psum_vld,
    output logic [P*8-1:0]       out_x,
    output logic [P*NW*PW-1:0]   out_psum,
    output logic [P-1:0]         out_psum_vld,
    output logic [P-1:0]         ovf,
    output logic [P-1:0]         coll
);

    logic [P-1:0][NW*8-1:0]  w_src;
    logic [P-1:0][NW*8-1:0]  w_a;
    logic [P-1:0]            vld_src;
    logic [P-1:0]            vld_a;
    logic [P-1:0]            rst_src;
    logic [P-1:0]            rst_a;
    logic [P-1:0]            flush_src;
    logic [P-1:0]            flush_a;
    logic [P-1:0][7:0]       x_a;
    logic [P-1:0][NW*PW-1:0] psum_o;

    // Skew chain sources: PE0 takes the row inputs, PE i takes PE i-1 stage A.
    always_comb begin
        w_src        = w_a;
        vld_src      = vld_a;
        rst_src      = rst_a;
        flush_src    = flush_a;
        w_src[0]     = in_w;
        vld_src[0]   = in_vld;
        rst_src[0]   = in_rst;
        flush_src[0] = in_flush;
        for (int i = 1; i < P; i++) begin
            w_src[i]     = w_a[i-1];
            vld_src[i]   = vld_a[i-1];
            rst_src[i]   = rst_a[i-1];
            flush_src[i] = flush_a[i-1];
        end
    end

    // Stage A: one skew register per PE plus the per-column activation latch,
    // which doubles as the forward path to the next row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_a     <= '0;
            vld_a   <= '0;
            rst_a   <= '0;
            flush_a <= '0;
            x_a     <= '0;
        end else begin
            w_a     <= w_src;
            vld_a   <= vld_src;
            rst_a   <= rst_src;
            flush_a <= flush_src;
            x_a     <= in_x;
        end
    end

    assign out_x    = x_a;
    assign out_psum = psum_o;

    for (genvar gi = 0; gi < P; gi++) begin : g_pe
        conv_sa_pe_mw #(
            .NW  (NW),
            .PW  (PW),
            .SAT (SAT)
        ) u_pe (
            .clk          (clk),
            .rst_n        (rst_n),
            .w_a          (w_a[gi]),
            .vld_a        (vld_a[gi]),
            .rst_a        (rst_a[gi]),
            .flush_a      (flush_a[gi]),
            .x_a          (x_a[gi]),
            .psum_in      (in_psum[gi*NW*PW +: NW*PW]),
            .psum_vld_in  (in_psum_vld[gi]),
            .psum_out     (psum_o[gi]),
            .psum_vld_out (out_psum_vld[gi]),
            .ovf          (ovf[gi]),
            .coll         (coll[gi])
        );
    end

endmodule

// File: tb/tb_conv_sa_pe_row_mw.sv
// Randomised + directed bench for conv_sa_pe_row_mw. Two rows (saturating and
// wrapping) share one stimulus stream; a per-element arithmetic model predicts
// each drained word and its arrival cycle, a monitor pops and compares.
module tb_conv_sa_pe_row_mw;

    localparam int P  = 4;
    localparam int NW = 2;
    localparam int PW = 19;
    localparam longint AMAX = (64'sd1 <<< (PW-1)) - 1;
    localparam longint AMIN = -(64'sd1 <<< (PW-1));

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NW*8-1:0]    in_w = '0;
    logic               in_vld = 1'b0;
    logic               in_rst = 1'b0;
    logic               in_flush = 1'b0;
    logic [P*8-1:0]     in_x = '0;
    logic [P*NW*PW-1:0] in_psum = '0;
    logic [P-1:0]       in_psum_vld = '0;

    logic [P*8-1:0]     s_ox, w_ox;
    logic [P*NW*PW-1:0] s_ps, w_ps;
    logic [P-1:0]       s_pv, w_pv, s_ovf, w_ovf, s_coll, w_coll;

    conv_sa_pe_row_mw #(.P(P), .NW(NW), .PW(PW), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_w(in_w), .in_vld(in_vld), .in_rst(in_rst),
        .in_flush(in_flush), .in_x(in_x), .in_psum(in_psum), .in_psum_vld(in_psum_vld),
        .out_x(s_ox), .out_psum(s_ps), .out_psum_vld(s_pv), .ovf(s_ovf), .coll(s_coll));

    conv_sa_pe_row_mw #(.P(P), .NW(NW), .PW(PW), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_w(in_w), .in_vld(in_vld), .in_rst(in_rst),
        .in_flush(in_flush), .in_x(in_x), .in_psum(in_psum), .in_psum_vld(in_psum_vld),
        .out_x(w_ox), .out_psum(w_ps), .out_psum_vld(w_pv), .ovf(w_ovf), .coll(w_coll));

    always #5 clk = ~clk;

    typedef struct {
        logic [NW*PW-1:0] vs;
        logic [NW*PW-1:0] vw;
    } exp_t;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // reference model state
    longint acc_s [P][NW];
    longint acc_w [P][NW];
    bit     ovf_s [P];
    bit     ovf_w [P];
    bit     coll_m [P];
    logic [P*8-1:0] xh [16];
    // expected drain words, indexed by arrival cycle
    bit               rv [64][P];
    bit               rl [64][P];
    logic [NW*PW-1:0] rs [64][P];
    logic [NW*PW-1:0] rw [64][P];
    exp_t             q [P][$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint wrap_pw(input longint s);
        longint m;
        m = s & ((64'sd1 <<< PW) - 1);
        if (m > AMAX) m = m - (64'sd1 <<< PW);
        return m;
    endfunction

    // One accumulate: exact sum, then clamp or wrap if outside the signed PW range.
    function automatic longint lane_step(input longint a, input longint p, input bit r,
                                         input bit sat, output bit of);
        longint s;
        s  = (r ? 64'sd0 : a) + p;
        of = (s > AMAX) || (s < AMIN);
        if (!of) return s;
        if (sat) return (s > AMAX) ? AMAX : AMIN;
        return wrap_pw(s);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < P; i++) begin
            for (int k = 0; k < NW; k++) begin
                acc_s[i][k] = 0;
                acc_w[i][k] = 0;
            end
            ovf_s[i] = 0; ovf_w[i] = 0; coll_m[i] = 0;
            q[i].delete();
            for (int s = 0; s < 64; s++) rv[s][i] = 0;
        end
    endtask

    // Drive one cycle of inputs; element (if valid) applies to every column in order.
    task automatic step(input bit v, input bit r, input bit f, input logic [NW*8-1:0] w,
                        input logic [P*8-1:0] xv, input logic [P-1:0] psv,
                        input logic [P*NW*PW-1:0] ps);
        int c, sl;
        bit of;
        longint wk, xi;
        logic [NW*PW-1:0] cs, cw;
        @(posedge clk); #1;
        c = cyc;
        in_w = w; in_vld = v; in_rst = r; in_flush = f;
        xh[c & 15] = xv;
        for (int i = 0; i < P; i++) in_x[i*8 +: 8] = xh[(c - i) & 15][i*8 +: 8];
        in_psum_vld = psv;
        in_psum = ps;
        if (v) begin
            for (int i = 0; i < P; i++) begin
                xi = longint'($signed(xv[i*8 +: 8]));
                if (r) begin ovf_s[i] = 0; ovf_w[i] = 0; end
                for (int k = 0; k < NW; k++) begin
                    wk = longint'($signed(w[k*8 +: 8]));
                    acc_s[i][k] = lane_step(acc_s[i][k], wk * xi, r, 1'b1, of);
                    if (of) ovf_s[i] = 1;
                    acc_w[i][k] = lane_step(acc_w[i][k], wk * xi, r, 1'b0, of);
                    if (of) ovf_w[i] = 1;
                    cs[k*PW +: PW] = acc_s[i][k][PW-1:0];
                    cw[k*PW +: PW] = acc_w[i][k][PW-1:0];
                end
                if (f) begin
                    sl = (c + i + 3) & 63;
                    rv[sl][i] = 1; rl[sl][i] = 1; rs[sl][i] = cs; rw[sl][i] = cw;
                end
            end
        end
        for (int i = 0; i < P; i++) begin
            if (psv[i]) begin
                sl = (c + 1) & 63;
                if (rv[sl][i] && rl[sl][i]) coll_m[i] = 1;
                else begin
                    rv[sl][i] = 1; rl[sl][i] = 0;
                    rs[sl][i] = ps[i*NW*PW +: NW*PW];
                    rw[sl][i] = ps[i*NW*PW +: NW*PW];
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(0, 0, 0, '0, '0, '0, '0);
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < P; i++) begin
            chk($sformatf("%s_psum_s%0d", tag, i), 64'(s_ps[i*NW*PW +: NW*PW]), 64'd0);
            chk($sformatf("%s_psum_w%0d", tag, i), 64'(w_ps[i*NW*PW +: NW*PW]), 64'd0);
        end
        chk({tag, "_vld"},  64'({s_pv, w_pv}), 64'd0);
        chk({tag, "_ovf"},  64'({s_ovf, w_ovf}), 64'd0);
        chk({tag, "_coll"}, 64'({s_coll, w_coll}), 64'd0);
        chk({tag, "_outx"}, 64'({s_ox, w_ox}), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        rst_n = 0;
        in_vld = 0; in_rst = 0; in_flush = 0; in_psum_vld = '0;
        model_clear();
        #2;
        check_zero(tag);
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic check_flags(input string tag);
        idle(10);
        for (int i = 0; i < P; i++) begin
            chk($sformatf("%s_ovf_sat%0d", tag, i),  64'(s_ovf[i]),  64'(ovf_s[i]));
            chk($sformatf("%s_ovf_wrap%0d", tag, i), 64'(w_ovf[i]),  64'(ovf_w[i]));
            chk($sformatf("%s_coll_sat%0d", tag, i), 64'(s_coll[i]), 64'(coll_m[i]));
            chk($sformatf("%s_coll_wrap%0d", tag, i), 64'(w_coll[i]), 64'(coll_m[i]));
        end
    endtask

    function automatic logic [P*NW*PW-1:0] rnd_ps();
        logic [P*NW*PW-1:0] r;
        logic [31:0] u;
        r = '0;
        for (int j = 0; j < P*NW; j++) begin
            u = $urandom;
            r[j*PW +: PW] = u[PW-1:0];
        end
        return r;
    endfunction

    function automatic logic [P-1:0] rnd_psv();
        logic [P-1:0] r;
        for (int i = 0; i < P; i++) r[i] = ($urandom_range(3) == 0);
        return r;
    endfunction

    // cycle counter, read by driver (after the edge) and monitor (falling edge)
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: release due expectations into the queues, pop on DUT output.
    initial begin
        logic [P*8-1:0] prev_x;
        logic prev_rstn;
        int slot;
        exp_t e;
        prev_x = '0;
        prev_rstn = 0;
        forever begin
            @(negedge clk);
            slot = cyc & 63;
            for (int i = 0; i < P; i++) begin
                if (rv[slot][i]) begin
                    q[i].push_back('{vs: rs[slot][i], vw: rw[slot][i]});
                    rv[slot][i] = 0;
                end
                if (s_pv[i] || w_pv[i] || q[i].size() != 0) begin
                    if (q[i].size() == 0) begin
                        chk($sformatf("unexpected_vld_col%0d", i), 64'({s_pv[i], w_pv[i]}), 64'd0);
                    end else begin
                        e = q[i].pop_front();
                        chk($sformatf("psum_vld_col%0d", i), 64'({s_pv[i], w_pv[i]}), 64'd3);
                        chk($sformatf("psum_sat_col%0d", i), 64'(s_ps[i*NW*PW +: NW*PW]), 64'(e.vs));
                        chk($sformatf("psum_wrap_col%0d", i), 64'(w_ps[i*NW*PW +: NW*PW]), 64'(e.vw));
                    end
                end
            end
            chk("out_x_sat",  64'(s_ox), (!rst_n || !prev_rstn) ? 64'd0 : 64'(prev_x));
            chk("out_x_wrap", 64'(w_ox), (!rst_n || !prev_rstn) ? 64'd0 : 64'(prev_x));
            prev_x = in_x;
            prev_rstn = rst_n;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [P*8-1:0] x1234;
        logic [P*NW*PW-1:0] ps77;
        for (int j = 0; j < 16; j++) xh[j] = '0;
        model_clear();
        x1234 = {8'd4, 8'd3, 8'd2, 8'd1};
        ps77 = '0;
        for (int j = 0; j < P*NW; j++) ps77[j*PW +: PW] = PW'(77);

        // power-on reset
        repeat (3) @(posedge clk);
        #1;
        check_zero("por");
        rst_n = 1;
        idle(4);

        // 1: three-element vector w=(3,-2), x=i+1
        step(1, 1, 0, {8'hFE, 8'h03}, x1234, '0, '0);
        step(1, 0, 0, {8'hFE, 8'h03}, x1234, '0, '0);
        step(1, 0, 1, {8'hFE, 8'h03}, x1234, '0, '0);
        check_flags("t1");

        // 2: same vector with bubbles carrying random flags
        step(1, 1, 0, {8'hFE, 8'h03}, x1234, '0, '0);
        step(0, 1'($urandom), 1'($urandom), 16'($urandom), $urandom, '0, '0);
        step(1, 0, 0, {8'hFE, 8'h03}, x1234, '0, '0);
        step(0, 1'($urandom), 1'($urandom), 16'($urandom), $urandom, '0, '0);
        step(1, 0, 1, {8'hFE, 8'h03}, x1234, '0, '0);
        check_flags("t2");

        // 3: 17 x (127*127) overflows the 19-bit accumulator
        for (int j = 0; j < 17; j++)
            step(1, j == 0, j == 16, {8'd127, 8'd127}, {4{8'd127}}, '0, '0);
        check_flags("t3");

        // 4: length-1 vector, then a vector continuing without restart
        step(1, 1, 1, {8'h80, 8'h80}, {4{8'h80}}, '0, '0);
        step(1, 0, 1, {8'd2, 8'd1}, x1234, '0, '0);
        check_flags("t4");

        // 5: upstream word lands on column 2's local flush cycle
        step(1, 1, 1, {8'd5, 8'hF9}, x1234, '0, '0);
        idle(3);
        step(0, 0, 0, '0, '0, 4'b1111, ps77);
        check_flags("t5");

        // 6: reset mid-vector, then a clean vector
        step(1, 1, 0, {8'd9, 8'd4}, x1234, '0, '0);
        step(1, 0, 0, {8'd9, 8'd4}, x1234, '0, '0);
        do_reset("midrst");
        step(1, 1, 0, {8'd7, 8'hFD}, x1234, '0, '0);
        step(1, 0, 1, {8'd7, 8'hFD}, x1234, '0, '0);
        check_flags("t6");

        // random traffic with upstream words and collisions
        for (int j = 0; j < 400; j++)
            step(($urandom_range(3) != 0), ($urandom_range(7) == 0), ($urandom_range(4) == 0),
                 16'($urandom), $urandom, rnd_psv(), rnd_ps());
        check_flags("rnd");

        for (int i = 0; i < P; i++)
            chk($sformatf("leftover_col%0d", i), 64'(q[i].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
